combine_user_arbiter: RTL and testbench
=======================================

Name: combine_user_arbiter

Overview:
Parametrised successor of the per-slot combine user scheduler. It tracks per-user input-buffer readiness through ping-pong toggle detection, and queues multiple ready events per user in saturating counters. Each cycle it picks a user by single-cycle rotating-priority or fixed-priority selection. It drives the combine engine with a request / complete handshake that has a timeout. It sits between the input ping-pong buffers and the combine datapath, in the i_core_clk domain.

Parameters:
NUM_USERS, 8, number of users / ping-pong indicators (2..16)
IDX_W, 3, user index width, equal to clog2(NUM_USERS)
PEND_W, 2, per-user pending-count width; saturates at 2^PEND_W-1
TMO_W, 16, timeout counter width

Ports:
i_core_clk  in  1  core clock, all logic on rising edge
i_rx_rst  in  1  asynchronous, active-high reset
i_fsm_clr  in  1  synchronous clear; same effect as reset, applied at the clock edge
i_slot_start  in  1  slot start pulse
i_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
i_pingpong  in  NUM_USERS  ping-pong indicators; any bit toggle = one buffer ready for that user
i_user_en  in  NUM_USERS  eligibility mask; a masked user accumulates pending but is never granted
i_comp  in  1  current code block combine complete, 1-cycle pulse
i_tmo_cycles  in  TMO_W  cycles allowed in PROG; 0 disables the timeout
o_req  out  1  combine process request, high while state = PROG
o_user_index  out  IDX_W  granted user index
o_grant_valid  out  1  high in PROG and COMP
o_pending_any  out  1  OR over all users of (pending != 0)
o_tmo_pulse  out  1  1-cycle pulse when a timeout forces exit from PROG
o_ovf  out  NUM_USERS  sticky per-user overflow flag

Behaviour:
- Reset and clear values: state = IDLE; pingpong_1d = 0; all pending counts = 0; rr_ptr = 0; o_user_index = 0; tmo_cnt = 0; o_ovf = 0. All outputs are low.
- Toggle detect: inc[i] = i_pingpong[i] != pingpong_1d[i]. pingpong_1d is a registered copy of i_pingpong.
- Pending update, per user, per edge:
  - inc only: pending + 1, saturating at max.
  - inc while already at max: pending holds, and o_ovf[i] is set (sticky until reset or clear).
  - dec only: pending − 1, where dec = (state == COMP) and (i == grant).
  - inc and dec together: pending unchanged.
- Eligible vector: elig[i] = (pending[i] != 0) & i_user_en[i].
- Selection (combinational, single cycle):
  - Mode 0: first set bit of elig searching upward from rr_ptr, wrapping from NUM_USERS−1 to 0.
  - Mode 1: lowest set bit of elig.
- State machine, one-hot:
  - IDLE: i_slot_start = 1 -> ARB.
  - ARB: elig != 0 -> PROG, with grant and o_user_index registered at the same edge. elig = 0 -> stay in ARB; no per-cycle pointer shifting.
  - PROG: o_req = 1.
    - i_comp = 1 -> COMP.
    - Else if i_tmo_cycles != 0 and tmo_cnt == i_tmo_cycles − 1 -> COMP, with o_tmo_pulse = 1 in the first COMP cycle.
    - tmo_cnt counts PROG cycles and is cleared on entry to PROG.
  - COMP: single cycle. Decrement the granted user's pending. rr_ptr = (grant + 1) mod NUM_USERS; rr_ptr updates in both modes. -> ARB.
- i_slot_start outside IDLE is ignored.
- The FSM never returns to IDLE except via reset or i_fsm_clr.
- If i_fsm_clr and i_slot_start are high in the same cycle, clear wins.
- A timeout consumes one pending entry, exactly like a normal completion.
- i_user_en is deasserted for the granted user during PROG: the grant is not affected.
- Latency from a toggle sampled at edge E while in ARB:
  - pending = 1 after edge E.
  - state = PROG and o_req = 1 after edge E+1.
- Back-to-back operation: i_comp at edge C -> COMP after C -> ARB after C+1 -> PROG again after C+2, if any user is eligible.
- o_user_index holds its last value in IDLE and ARB.

Test Plan:
- Reset, then slot start with no toggles -> state stays ARB, o_req = 0, o_pending_any = 0.
- Toggle users 2 and 5 together, mode 0, rr_ptr = 0 -> user 2 granted; after i_comp, user 5 granted; then idle in ARB, and o_pending_any = 0 after the second COMP.
- Toggle user 3 five times with PEND_W = 2 and no grant (i_user_en[3] = 0) -> pending[3] = 3 and o_ovf[3] = 1. Then enable it -> exactly 3 grants of user 3.
- Mode 1 with users 1, 4 and 6 pending -> grant order is 1, 4, 6. New toggles on user 1 during each PROG -> user 1 is re-granted first every time.
- i_tmo_cycles = 4, i_comp never asserted -> o_req is high for exactly 4 cycles, then o_tmo_pulse = 1 and the pending count decrements.
- Assert i_rx_rst in the middle of PROG -> all outputs go to 0 immediately (asynchronously). After release the FSM waits in IDLE for i_slot_start.

Source files
------------

// File: rtl/combine_user_arbiter.sv
// Per-user combine arbiter: ping-pong toggle detection feeds saturating pending
// counters; a one-hot FSM grants users (round-robin or fixed) with a timed handshake.
module combine_user_arbiter #(
  parameter int NUM_USERS = 8,
  parameter int IDX_W     = 3,
  parameter int PEND_W    = 2,
  parameter int TMO_W     = 16
) (
  input  logic                 i_core_clk,
  input  logic                 i_rx_rst,
  input  logic                 i_fsm_clr,
  input  logic                 i_slot_start,
  input  logic                 i_mode,
  input  logic [NUM_USERS-1:0] i_pingpong,
  input  logic [NUM_USERS-1:0] i_user_en,
  input  logic                 i_comp,
  input  logic [TMO_W-1:0]     i_tmo_cycles,
  output logic                 o_req,
  output logic [IDX_W-1:0]     o_user_index,
  output logic                 o_grant_valid,
  output logic                 o_pending_any,
  output logic                 o_tmo_pulse,
  output logic [NUM_USERS-1:0] o_ovf
);

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_ARB  = 4'b0010;
  localparam logic [3:0] S_PROG = 4'b0100;
  localparam logic [3:0] S_COMP = 4'b1000;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [3:0]                        state_q, state_d;
  logic [NUM_USERS-1:0]              pp_1d_q, pp_1d_d;
  logic [NUM_USERS-1:0][PEND_W-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]                  user_idx_q, user_idx_d;
  logic [TMO_W-1:0]                  tmo_cnt_q, tmo_cnt_d;
  logic [NUM_USERS-1:0]              ovf_q, ovf_d;
  logic                              tmo_pulse_q, tmo_pulse_d;

  logic [NUM_USERS-1:0] elig;
  logic [NUM_USERS-1:0] nz;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 tmo_hit;

  always_comb begin
    for (int i = 0; i < NUM_USERS; i++) begin
      nz[i]   = (pend_q[i] != '0);
      elig[i] = nz[i] & i_user_en[i];
    end
  end

  // Scan downward so the lowest index (or lowest offset from rr_ptr) wins last.
  always_comb begin
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_USERS - 1; k >= 0; k--) begin
      if (i_mode) j = k;
      else begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_USERS) j = j - NUM_USERS;
      end
      if (elig[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
  end

  assign tmo_hit = (i_tmo_cycles != '0) && (tmo_cnt_q == i_tmo_cycles - TMO_W'(1));

  always_comb begin
    state_d     = state_q;
    pp_1d_d     = i_pingpong;
    pend_d      = pend_q;
    rr_ptr_d    = rr_ptr_q;
    user_idx_d  = user_idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    ovf_d       = ovf_q;
    tmo_pulse_d = 1'b0;

    for (int i = 0; i < NUM_USERS; i++) begin
      logic inc, dec;
      inc = i_pingpong[i] ^ pp_1d_q[i];
      dec = (state_q == S_COMP) && (user_idx_q == IDX_W'(i));
      if (inc && !dec) begin
        if (pend_q[i] == PEND_MAX) ovf_d[i] = 1'b1;
        else                       pend_d[i] = pend_q[i] + PEND_W'(1);
      end else if (dec && !inc && pend_q[i] != '0) begin
        pend_d[i] = pend_q[i] - PEND_W'(1);
      end
    end

    case (state_q)
      S_IDLE: if (i_slot_start) state_d = S_ARB;
      S_ARB: begin
        if (sel_found) begin
          state_d    = S_PROG;
          user_idx_d = sel_idx;
          tmo_cnt_d  = '0;
        end
      end
      S_PROG: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (i_comp) state_d = S_COMP;
        else if (tmo_hit) begin
          state_d     = S_COMP;
          tmo_pulse_d = 1'b1;
        end
      end
      S_COMP: begin
        state_d  = S_ARB;
        rr_ptr_d = (user_idx_q == IDX_W'(NUM_USERS - 1)) ? '0 : user_idx_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (i_fsm_clr) begin
      state_d     = S_IDLE;
      pp_1d_d     = '0;
      pend_d      = '0;
      rr_ptr_d    = '0;
      user_idx_d  = '0;
      tmo_cnt_d   = '0;
      ovf_d       = '0;
      tmo_pulse_d = 1'b0;
    end
  end

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state_q     <= S_IDLE;
      pp_1d_q     <= '0;
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      user_idx_q  <= '0;
      tmo_cnt_q   <= '0;
      ovf_q       <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pp_1d_q     <= pp_1d_d;
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      user_idx_q  <= user_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ovf_q       <= ovf_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign o_req         = (state_q == S_PROG);
  assign o_grant_valid = (state_q == S_PROG) || (state_q == S_COMP);
  assign o_user_index  = user_idx_q;
  assign o_pending_any = |nz;
  assign o_tmo_pulse   = tmo_pulse_q;
  assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_combine_user_arbiter.sv
// Directed-vector bench for combine_user_arbiter with hand-computed expectations.
module tb_combine_user_arbiter;
  localparam int N = 8;
  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_ARB  = 4'b0010;
  localparam logic [3:0] S_COMP = 4'b1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fsm_clr = 1'b0, slot_start = 1'b0, mode = 1'b0, comp = 1'b0;
  logic [N-1:0] pingpong = '0, user_en = '1;
  logic [15:0]  tmo_cycles = '0;
  logic         req, grant_valid, pending_any, tmo_pulse;
  logic [2:0]   user_index;
  logic [N-1:0] ovf;

  int vecs = 0, errs = 0;
  int idx, cnt;

  combine_user_arbiter dut (
    .i_core_clk(clk), .i_rx_rst(rst), .i_fsm_clr(fsm_clr), .i_slot_start(slot_start),
    .i_mode(mode), .i_pingpong(pingpong), .i_user_en(user_en), .i_comp(comp),
    .i_tmo_cycles(tmo_cycles), .o_req(req), .o_user_index(user_index),
    .o_grant_valid(grant_valid), .o_pending_any(pending_any), .o_tmo_pulse(tmo_pulse),
    .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [N-1:0] m);
    pingpong = pingpong ^ m;
    tick();
  endtask

  task automatic wait_grant(output int gidx);
    int n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", req, 1);
    gidx = user_index;
  endtask

  // Pulse complete: leaves the bench in the ARB cycle after COMP.
  task automatic do_comp();
    comp = 1'b1;
    tick();
    comp = 1'b0;
    chk("comp_state", dut.state_q, S_COMP);
    tick();
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_state", dut.state_q, S_IDLE);
    chk("rst_req", req, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_pend", pending_any, 0);
    chk("rst_tmo", tmo_pulse, 0);
    chk("rst_idx", user_index, 0);
    chk("rst_ovf", ovf, 0);

    // Slot start with nothing pending: parks in ARB.
    slot_start = 1'b1; tick(); slot_start = 1'b0;
    repeat (3) tick();
    chk("arb_park", dut.state_q, S_ARB);
    chk("arb_req", req, 0);
    chk("arb_pend", pending_any, 0);

    // Users 2 and 5, round-robin from 0.
    toggle(8'h24);
    chk("lat_pend", pending_any, 1);
    chk("lat_req0", req, 0);
    tick();
    chk("lat_req1", req, 1);
    chk("rr_first", user_index, 2);
    chk("rr_gv", grant_valid, 1);
    do_comp();
    chk("b2b_arb", dut.state_q, S_ARB);
    tick();
    chk("b2b_req", req, 1);
    chk("rr_second", user_index, 5);
    do_comp();
    chk("rr_pend_empty", pending_any, 0);
    repeat (2) tick();
    chk("rr_idle_req", req, 0);
    chk("rr_idx_hold", user_index, 5);

    // Saturation with user 3 masked.
    user_en = 8'hF7;
    repeat (5) toggle(8'h08);
    tick();
    chk("ovf_flag", ovf, 8'h08);
    chk("ovf_noreq", req, 0);
    chk("ovf_pend", pending_any, 1);
    user_en = '1;
    for (int g = 0; g < 3; g++) begin
      wait_grant(idx);
      chk("sat_user", idx, 3);
      do_comp();
    end
    repeat (2) tick();
    chk("sat_done_req", req, 0);
    chk("sat_done_pend", pending_any, 0);

    // Fixed priority with user 1 re-arriving during some grants.
    mode = 1'b1;
    toggle(8'h52);
    wait_grant(idx); chk("fp_g0", idx, 1); toggle(8'h02); do_comp();
    wait_grant(idx); chk("fp_g1", idx, 1); do_comp();
    wait_grant(idx); chk("fp_g2", idx, 4); toggle(8'h02); do_comp();
    wait_grant(idx); chk("fp_g3", idx, 1); do_comp();
    wait_grant(idx); chk("fp_g4", idx, 6); do_comp();
    chk("fp_pend", pending_any, 0);

    // Timeout after 4 PROG cycles.
    mode = 1'b0;
    tmo_cycles = 16'd4;
    toggle(8'h01);
    wait_grant(idx);
    chk("tmo_user", idx, 0);
    cnt = 0;
    while (req && cnt < 20) begin
      cnt++;
      chk("tmo_no_early", tmo_pulse, 0);
      tick();
    end
    chk("tmo_req_cycles", cnt, 4);
    chk("tmo_pulse", tmo_pulse, 1);
    chk("tmo_comp_gv", grant_valid, 1);
    tick();
    chk("tmo_pulse_off", tmo_pulse, 0);
    chk("tmo_pend", pending_any, 0);
    tmo_cycles = '0;

    // Asynchronous reset in the middle of PROG.
    toggle(8'h80);
    wait_grant(idx);
    chk("ar_user", idx, 7);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", req, 0);
    chk("ar_gv", grant_valid, 0);
    chk("ar_idx", user_index, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_pend", pending_any, 0);
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("ar_idle", dut.state_q, S_IDLE);
    chk("ar_idle_req", req, 0);

    // Clear beats a simultaneous slot start.
    slot_start = 1'b1; tick();
    chk("start_arb", dut.state_q, S_ARB);
    fsm_clr = 1'b1; tick();
    fsm_clr = 1'b0; slot_start = 1'b0;
    chk("clr_idle", dut.state_q, S_IDLE);
    chk("clr_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
